// File: rtl/key_code_arbiter_if.sv
// Bus bundle for key_code_arbiter: requester valid/ready handshake plus the
// Avalon-MM write port that drives the key-code PIO register.
interface key_code_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int CODE_W  = 16
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*CODE_W-1:0] req_code;
    logic [NUM_REQ-1:0]        req_ready;
    logic [1:0]                m_address;
    logic                      m_chipselect;
    logic                      m_write_n;
    logic [31:0]               m_writedata;

    // master is the arbiter: it accepts key codes and masters the PIO write
    modport master (
        input  req_valid, req_code,
        output req_ready, m_address, m_chipselect, m_write_n, m_writedata
    );

    modport slave (
        output req_valid, req_code,
        input  req_ready, m_address, m_chipselect, m_write_n, m_writedata
    );
endinterface

// File: rtl/key_code_arbiter.sv
// Round-robin arbiter that queues key codes from several sources and writes
// them one at a time to the key-code PIO, holding each for a dwell period.
module key_code_arbiter #(
    parameter int NUM_REQ       = 3,
    parameter int CODE_W        = 16,
    parameter int FIFO_DEPTH    = 4,
    parameter int HOLD_CYCLES   = 1000,
    parameter bit CLEAR_ON_IDLE = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    key_code_arbiter_if.master          bus,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, WRITE, HOLD, CLEAR} state_t;

    state_t             state, state_nxt;
    logic               prev_hold;
    logic [CNT_W-1:0]   hold_cnt;
    logic [CODE_W-1:0]  last_code;

    logic [CODE_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [LVL_W-1:0]   level;
    logic [CODE_W-1:0]  head, push_code;
    logic               push, pop;

    logic [IDX_W-1:0]   rr_ptr, grant_idx, idx;
    logic [NUM_REQ-1:0] ready;
    logic               found;

    logic               cs_q, write_n_q;
    logic [31:0]        writedata_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ready     = '0;
        grant_idx = '0;
        idx       = '0;
        found     = 1'b0;
        if (level < LVL_W'(FIFO_DEPTH)) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
                if (!found && bus.req_valid[idx]) begin
                    found      = 1'b1;
                    grant_idx  = idx;
                    ready[idx] = 1'b1;
                end
            end
        end
    end

    assign push      = found;
    assign push_code = bus.req_code[int'(grant_idx)*CODE_W +: CODE_W];
    assign pop       = (state == WRITE);
    assign head      = mem[rd_ptr];

    // NOTE: queue storage is not reset; the pointers and level alone say which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_code;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            rr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + LVL_W'(push) - LVL_W'(pop);
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (level != '0)
                    state_nxt = WRITE;
                else if (CLEAR_ON_IDLE && prev_hold && (last_code != '0))
                    state_nxt = CLEAR;
            end
            WRITE:   state_nxt = HOLD;
            HOLD:    if (hold_cnt == '0) state_nxt = IDLE;
            CLEAR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are registered off the next state so they line up with WRITE/CLEAR.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            prev_hold   <= 1'b0;
            hold_cnt    <= '0;
            last_code   <= '0;
            cs_q        <= 1'b0;
            write_n_q   <= 1'b1;
            writedata_q <= '0;
        end else begin
            state     <= state_nxt;
            prev_hold <= (state == HOLD);
            if (state == WRITE) begin
                hold_cnt  <= CNT_W'(HOLD_CYCLES - 1);
                last_code <= head;
            end else if (state == HOLD) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
            if (state == CLEAR) last_code <= '0;
            cs_q      <= (state_nxt == WRITE) || (state_nxt == CLEAR);
            write_n_q <= !((state_nxt == WRITE) || (state_nxt == CLEAR));
            if (state_nxt == WRITE)
                writedata_q <= 32'(head);
            else if (state_nxt == CLEAR)
                writedata_q <= '0;
        end
    end

    assign bus.req_ready    = ready;
    assign bus.m_address    = 2'b00;
    assign bus.m_chipselect = cs_q;
    assign bus.m_write_n    = write_n_q;
    assign bus.m_writedata  = writedata_q;
    assign fifo_level       = level;
    assign busy             = (state != IDLE) || (level != '0);
endmodule

// File: tb/tb_key_code_arbiter.sv
// Bench for key_code_arbiter: two instances (clear-on-idle on and off) checked
// every cycle against a timestamp/queue model, plus hand-computed scenarios.
module tb_key_code_arbiter;
    localparam int NUM_REQ    = 3;
    localparam int CODE_W     = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int HOLD       = 8;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // unit 0: CLEAR_ON_IDLE = 0, unit 1: CLEAR_ON_IDLE = 1
    key_code_arbiter_if #(.NUM_REQ(NUM_REQ), .CODE_W(CODE_W)) bus_n ();
    key_code_arbiter_if #(.NUM_REQ(NUM_REQ), .CODE_W(CODE_W)) bus_c ();
    logic [LVL_W-1:0] lvl_n, lvl_c;
    logic             busy_n, busy_c;

    key_code_arbiter #(
        .NUM_REQ(NUM_REQ), .CODE_W(CODE_W), .FIFO_DEPTH(FIFO_DEPTH),
        .HOLD_CYCLES(HOLD), .CLEAR_ON_IDLE(1'b0)
    ) dut_n (
        .clk(clk), .reset(reset), .bus(bus_n), .fifo_level(lvl_n), .busy(busy_n)
    );

    key_code_arbiter #(
        .NUM_REQ(NUM_REQ), .CODE_W(CODE_W), .FIFO_DEPTH(FIFO_DEPTH),
        .HOLD_CYCLES(HOLD), .CLEAR_ON_IDLE(1'b1)
    ) dut_c (
        .clk(clk), .reset(reset), .bus(bus_c), .fifo_level(lvl_c), .busy(busy_c)
    );

    logic [NUM_REQ-1:0]        s_valid [2];
    logic [NUM_REQ*CODE_W-1:0] s_code  [2];
    assign bus_n.req_valid = s_valid[0];
    assign bus_n.req_code  = s_code[0];
    assign bus_c.req_valid = s_valid[1];
    assign bus_c.req_code  = s_code[1];

    logic [NUM_REQ-1:0] d_ready [2];
    logic               d_cs    [2];
    logic               d_wn    [2];
    logic [31:0]        d_wd    [2];
    logic [1:0]         d_addr  [2];
    logic [LVL_W-1:0]   d_lvl   [2];
    logic               d_busy  [2];
    assign d_ready[0] = bus_n.req_ready;    assign d_ready[1] = bus_c.req_ready;
    assign d_cs[0]    = bus_n.m_chipselect; assign d_cs[1]    = bus_c.m_chipselect;
    assign d_wn[0]    = bus_n.m_write_n;    assign d_wn[1]    = bus_c.m_write_n;
    assign d_wd[0]    = bus_n.m_writedata;  assign d_wd[1]    = bus_c.m_writedata;
    assign d_addr[0]  = bus_n.m_address;    assign d_addr[1]  = bus_c.m_address;
    assign d_lvl[0]   = lvl_n;              assign d_lvl[1]   = lvl_c;
    assign d_busy[0]  = busy_n;             assign d_busy[1]  = busy_c;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: an ordered list of queued codes plus the cycle at which the
    // output engine is next free; a code write occupies HOLD+1 cycles, a clear 1.
    logic [CODE_W-1:0]  mq        [2][8];
    int                 mq_n      [2];
    int                 ptr       [2];
    int                 free_at   [2];
    int                 last_kind [2];   // 0 none, 1 code write, 2 clear write
    logic [CODE_W-1:0]  last_code [2];
    logic [31:0]        wdata     [2];
    bit                 pend      [2];
    bit                 pend_code [2];
    logic [31:0]        pend_data [2];
    bit                 armed     [2];
    logic [NUM_REQ-1:0] xfer      [2];
    int                 cyc = 0;

    task automatic model_step(input int u);
        int                 g;
        bit                 idle_now, new_pend, new_code;
        logic [31:0]        new_data;
        logic [NUM_REQ-1:0] exp_rdy;
        idle_now = !pend[u] && (cyc >= free_at[u]);
        exp_rdy  = '0;
        g        = -1;
        if (mq_n[u] < FIFO_DEPTH) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int i;
                i = (ptr[u] + k) % NUM_REQ;
                if (g < 0 && s_valid[u][i]) g = i;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;

        if (armed[u]) begin
            check($sformatf("u%0d req_ready", u), d_ready[u], exp_rdy);
            check($sformatf("u%0d fifo_level", u), d_lvl[u], mq_n[u]);
            check($sformatf("u%0d busy", u), d_busy[u], !idle_now || (mq_n[u] != 0));
            check($sformatf("u%0d chipselect", u), d_cs[u], pend[u]);
            check($sformatf("u%0d write_n", u), d_wn[u], !pend[u]);
            check($sformatf("u%0d writedata", u), d_wd[u], pend[u] ? pend_data[u] : wdata[u]);
            check($sformatf("u%0d address", u), d_addr[u], 0);
        end
        xfer[u] = s_valid[u] & d_ready[u];

        if (reset) begin
            mq_n[u]      = 0;
            ptr[u]       = 0;
            free_at[u]   = cyc + 1;
            last_kind[u] = 0;
            last_code[u] = '0;
            wdata[u]     = '0;
            pend[u]      = 1'b0;
            armed[u]     = 1'b1;
        end else begin
            new_pend = 1'b0;
            new_code = 1'b0;
            new_data = '0;
            if (idle_now) begin
                if (mq_n[u] != 0) begin
                    new_pend = 1'b1;
                    new_code = 1'b1;
                    new_data = 32'(mq[u][0]);
                end else if (u == 1 && cyc == free_at[u] && last_kind[u] == 1 && last_code[u] != '0) begin
                    new_pend = 1'b1;
                end
            end
            if (pend[u]) begin
                wdata[u] = pend_data[u];
                if (pend_code[u]) begin
                    last_code[u] = CODE_W'(pend_data[u]);
                    for (int j = 0; j < 7; j++) mq[u][j] = mq[u][j+1];
                    mq_n[u]--;
                    free_at[u]   = cyc + HOLD + 1;
                    last_kind[u] = 1;
                end else begin
                    last_code[u] = '0;
                    free_at[u]   = cyc + 1;
                    last_kind[u] = 2;
                end
            end
            if (g >= 0) begin
                mq[u][mq_n[u]] = s_code[u][g*CODE_W +: CODE_W];
                mq_n[u]++;
                ptr[u] = (g + 1) % NUM_REQ;
            end
            pend[u]      = new_pend;
            pend_code[u] = new_code;
            pend_data[u] = new_data;
        end
    endtask

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) model_step(u);
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CODE_W-1:0] rand_code();
        if ($urandom_range(0, 3) == 0) return '0;
        return CODE_W'($urandom);
    endfunction

    initial begin
        int strobes;
        int rate;
        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            s_valid[u] = '0;
            s_code[u]  = '0;
        end
        repeat (2) step();
        reset = 1'b0;

        // Single code 0x001C from requester 1, then the automatic clear write.
        s_valid[1][1] = 1'b1;
        s_code[1][1*CODE_W +: CODE_W] = 16'h001C;
        #1;
        check("t1 ready pulse", d_ready[1], 3'b010);
        check("t1 reset level", d_lvl[1], 0);
        check("t1 reset busy", d_busy[1], 0);
        check("t1 reset chipselect", d_cs[1], 0);
        check("t1 reset writedata", d_wd[1], 0);
        step();
        s_valid[1] = '0;
        #1;
        check("t1 queued level", d_lvl[1], 1);
        check("t1 no early strobe", d_cs[1], 0);
        step(); #1;
        check("t1 write chipselect", d_cs[1], 1);
        check("t1 write strobe", d_wn[1], 0);
        check("t1 write data", d_wd[1], 32'h0000_001C);
        step(); #1;
        check("t1 hold strobe off", d_cs[1], 0);
        check("t1 hold data kept", d_wd[1], 32'h0000_001C);
        check("t1 level after pop", d_lvl[1], 0);
        repeat (9) step();
        #1;
        check("t1 clear chipselect", d_cs[1], 1);
        check("t1 clear data", d_wd[1], 32'h0);
        step(); #1;
        check("t1 busy after clear", d_busy[1], 0);
        check("t1 strobe off after clear", d_cs[1], 0);

        // Round-robin with all three requesters held valid; then reset mid-hold.
        reset = 1'b1;
        step();
        reset = 1'b0;
        s_valid[1] = 3'b111;
        s_code[1]  = {16'h00C2, 16'h00B1, 16'h00A0};
        for (int n = 0; n < 14; n++) begin
            #1;
            case (n)
                0: check("rr grant 0", d_ready[1], 3'b001);
                1: check("rr grant 1", d_ready[1], 3'b010);
                2: begin
                    check("rr grant 2", d_ready[1], 3'b100);
                    check("rr first write", d_wd[1], 32'hA0);
                end
                3: begin
                    check("rr grant 0 again", d_ready[1], 3'b001);
                    check("push+pop level", d_lvl[1], 2);
                end
                4: check("rr grant 1 again", d_ready[1], 3'b010);
                5: begin
                    check("full level", d_lvl[1], 4);
                    check("full no ready", d_ready[1], 3'b000);
                end
                12: begin
                    check("rr second write", d_wd[1], 32'hB1);
                    check("rr second strobe", d_cs[1], 1);
                    check("full during pop", d_ready[1], 3'b000);
                end
                13: check("accept after pop", d_ready[1], 3'b100);
                default: ;
            endcase
            step();
        end
        reset = 1'b1;
        s_valid[1] = '0;
        step();
        reset = 1'b0;
        #1;
        check("reset flushes level", d_lvl[1], 0);
        check("reset drops busy", d_busy[1], 0);
        check("reset strobe off", d_cs[1], 0);
        strobes = 0;
        for (int n = 0; n < 20; n++) begin
            step();
            if (d_cs[1]) strobes++;
        end
        check("no write after reset", strobes, 0);

        // CLEAR_ON_IDLE = 0: no clear write, data held; code 0x0000 written normally.
        s_valid[0][2] = 1'b1;
        s_code[0][2*CODE_W +: CODE_W] = 16'h0055;
        #1;
        check("t6 ready", d_ready[0], 3'b100);
        step();
        s_valid[0] = '0;
        step(); #1;
        check("t6 write data", d_wd[0], 32'h55);
        check("t6 write strobe", d_cs[0], 1);
        repeat (10) step();
        #1;
        check("t6 no clear strobe", d_cs[0], 0);
        check("t6 data retained", d_wd[0], 32'h55);
        s_valid[0][0] = 1'b1;
        s_code[0][0 +: CODE_W] = 16'h0000;
        #1;
        check("t6 zero code ready", d_ready[0], 3'b001);
        step();
        s_valid[0] = '0;
        step(); #1;
        check("t6 zero code strobe", d_cs[0], 1);
        check("t6 zero code data", d_wd[0], 32'h0);
        repeat (12) step();
        #1;
        check("t6 idle after zero", d_busy[0], 0);

        // Randomized traffic: dense phase fills the queue, sparse phase exercises clears.
        for (int n = 0; n < 4000; n++) begin
            rate  = (n < 2000) ? 6 : 40;
            reset = ($urandom_range(0, 499) == 0);
            for (int u = 0; u < 2; u++) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (s_valid[u][i]) begin
                        if (xfer[u][i]) begin
                            if ($urandom_range(0, 1) == 0) s_valid[u][i] = 1'b0;
                            else s_code[u][i*CODE_W +: CODE_W] = rand_code();
                        end else if ($urandom_range(0, 31) == 0) begin
                            s_valid[u][i] = 1'b0;
                        end
                    end else if ($urandom_range(0, rate) == 0) begin
                        s_valid[u][i] = 1'b1;
                        s_code[u][i*CODE_W +: CODE_W] = rand_code();
                    end
                end
            end
            step();
        end
        reset = 1'b0;
        for (int u = 0; u < 2; u++) s_valid[u] = '0;
        repeat (60) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
